occ_rx_link_sync: RTL and testbench

Receive-side link synchronisation responder for the OCC PHY. It sits between the GTP PHY RX datapath and the user logic, and services the resync/synced handshake that link users initiate. It acquires lock on the periodic IDLE comma and declares loss of lock on errors or missing commas. It also forwards non-IDLE words to the user with a valid strobe.

---
 rtl/occ_rx_link_sync.sv | 166 ++++++++++++++++
 tb/tb_occ_rx_link_sync.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/occ_rx_link_sync.sv
// OCC PHY receive-side link synchroniser: comma lock, loss detection,
// resync/blind handshake and forwarding of non-IDLE words.
module occ_rx_link_sync #(
  parameter logic [15:0] g_IDLE         = 16'h95bc,
  parameter logic [1:0]  g_IDLE_K       = 2'b01,
  parameter int          g_ACQ_COUNT    = 4,
  parameter int          g_MAX_IDLE_GAP = 64,
  parameter int          g_ERR_THRESH   = 3,
  parameter int          g_BLIND_PERIOD = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_rdy_i,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_k_i,
  input  logic        rx_enc_err_i,
  input  logic        rx_buf_err_i,
  input  logic        rx_resync_i,
  output logic        rx_synced_o,
  output logic [15:0] rx_data_o,
  output logic [1:0]  rx_k_o,
  output logic        rx_valid_o,
  output logic [7:0]  err_cnt_o,
  output logic [7:0]  sync_loss_cnt_o
);

  typedef enum logic [1:0] {
    UNSYNC,
    BLIND,
    ACQUIRE,
    SYNCED
  } state_t;

  localparam logic [7:0]  ACQ_N  = 8'(g_ACQ_COUNT);
  localparam logic [15:0] GAP_N  = 16'(g_MAX_IDLE_GAP);
  localparam logic [7:0]  ERR_N  = 8'(g_ERR_THRESH);
  localparam logic [7:0]  BLIND_LAST =
    (g_BLIND_PERIOD > 1) ? 8'(g_BLIND_PERIOD - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  blind_q, blind_d;
  logic [7:0]  acq_q, acq_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  errw_q, errw_d;
  logic        resync_q;

  logic        idle, err, rise, loss;
  logic [7:0]  acq_inc;
  logic [15:0] gap_inc;
  logic [7:0]  errw_inc;
  logic        valid_d;

  assign idle = (rx_data_i == g_IDLE) && (rx_k_i == g_IDLE_K)
             && !rx_enc_err_i;
  assign err  = rx_enc_err_i | rx_buf_err_i
             | ((rx_k_i != 2'b00) && !idle);
  assign rise = rx_resync_i & ~resync_q;

  assign acq_inc  = idle ? acq_q + 8'd1 : 8'd0;
  assign gap_inc  = idle ? 16'd0 : gap_q + 16'd1;
  assign errw_inc = idle ? 8'd0
                  : (err ? errw_q + 8'd1 : errw_q);

  // Any way out of SYNCED other than a plain resync counts as a loss.
  assign loss = (state_q == SYNCED)
             && (!rx_rdy_i || rx_buf_err_i
                 || gap_inc == GAP_N || errw_inc == ERR_N);

  assign valid_d = (state_q == SYNCED) && !idle && !err && !loss;

  always_comb begin
    state_d = state_q;
    blind_d = blind_q;
    acq_d   = acq_q;
    gap_d   = gap_q;
    errw_d  = errw_q;
    if (!rx_rdy_i) begin
      state_d = UNSYNC;
      blind_d = 8'd0;
      acq_d   = 8'd0;
      gap_d   = 16'd0;
      errw_d  = 8'd0;
    end else if (rise) begin
      state_d = BLIND;
      blind_d = 8'd0;
      acq_d   = 8'd0;
      gap_d   = 16'd0;
      errw_d  = 8'd0;
    end else begin
      unique case (state_q)
        UNSYNC: begin
          state_d = ACQUIRE;
          acq_d   = 8'd0;
        end
        BLIND: begin
          if (blind_q >= BLIND_LAST) begin
            state_d = ACQUIRE;
            acq_d   = 8'd0;
          end else begin
            blind_d = blind_q + 8'd1;
          end
        end
        ACQUIRE: begin
          if (acq_inc == ACQ_N) begin
            state_d = SYNCED;
            acq_d   = 8'd0;
            gap_d   = 16'd0;
            errw_d  = 8'd0;
          end else begin
            acq_d = acq_inc;
          end
        end
        SYNCED: begin
          if (loss) begin
            state_d = UNSYNC;
            gap_d   = 16'd0;
            errw_d  = 8'd0;
          end else begin
            gap_d  = gap_inc;
            errw_d = errw_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= UNSYNC;
      blind_q  <= 8'd0;
      acq_q    <= 8'd0;
      gap_q    <= 16'd0;
      errw_q   <= 8'd0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      blind_q  <= blind_d;
      acq_q    <= acq_d;
      gap_q    <= gap_d;
      errw_q   <= errw_d;
      resync_q <= rx_resync_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_o       <= 16'd0;
      rx_k_o          <= 2'b00;
      rx_valid_o      <= 1'b0;
      err_cnt_o       <= 8'd0;
      sync_loss_cnt_o <= 8'd0;
    end else begin
      rx_data_o  <= rx_data_i;
      rx_k_o     <= rx_k_i;
      rx_valid_o <= valid_d;
      if (err && (state_q == ACQUIRE || state_q == SYNCED)
          && err_cnt_o != 8'hff)
        err_cnt_o <= err_cnt_o + 8'd1;
      if (loss && sync_loss_cnt_o != 8'hff)
        sync_loss_cnt_o <= sync_loss_cnt_o + 8'd1;
    end
  end

  assign rx_synced_o = (state_q == SYNCED);

endmodule

// File: tb/tb_occ_rx_link_sync.sv
// Directed bench for occ_rx_link_sync: acquisition, forwarding,
// loss conditions, resync/blind timing and reset.
module tb_occ_rx_link_sync;

  logic        clk_i;
  logic        rst_n_i;
  logic        rx_rdy_i;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_k_i;
  logic        rx_enc_err_i;
  logic        rx_buf_err_i;
  logic        rx_resync_i;
  logic        rx_synced_o;
  logic [15:0] rx_data_o;
  logic [1:0]  rx_k_o;
  logic        rx_valid_o;
  logic [7:0]  err_cnt_o;
  logic [7:0]  sync_loss_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  occ_rx_link_sync dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .rx_rdy_i        (rx_rdy_i),
    .rx_data_i       (rx_data_i),
    .rx_k_i          (rx_k_i),
    .rx_enc_err_i    (rx_enc_err_i),
    .rx_buf_err_i    (rx_buf_err_i),
    .rx_resync_i     (rx_resync_i),
    .rx_synced_o     (rx_synced_o),
    .rx_data_o       (rx_data_o),
    .rx_k_o          (rx_k_o),
    .rx_valid_o      (rx_valid_o),
    .err_cnt_o       (err_cnt_o),
    .sync_loss_cnt_o (sync_loss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic word(input logic [15:0] d, input logic [1:0] k);
    rx_data_i = d;
    rx_k_i    = k;
  endtask

  task automatic acquire(input string tag);
    word(16'h95bc, 2'b01);
    tick(5);
    chk(tag, rx_synced_o, 1);
  endtask

  int  cnt;
  bit  seen;

  initial begin
    rst_n_i      = 1'b0;
    rx_rdy_i     = 1'b1;
    rx_enc_err_i = 1'b0;
    rx_buf_err_i = 1'b0;
    rx_resync_i  = 1'b0;
    word(16'h1234, 2'b00);
    #3;
    chk("rst_synced", rx_synced_o, 0);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_losscnt", sync_loss_cnt_o, 0);
    #9;
    rst_n_i = 1'b1;

    // IDLE only every 13th word never reaches 4 in a row
    seen = 0;
    for (int p = 0; p < 5; p++) begin
      word(16'h1234, 2'b00);
      for (int i = 0; i < 12; i++) begin
        tick();
        if (rx_synced_o) seen = 1;
      end
      word(16'h95bc, 2'b01);
      tick();
      if (rx_synced_o) seen = 1;
    end
    chk("sparse_idle_nosync", 32'(seen), 0);
    word(16'h1234, 2'b00);
    tick();

    word(16'h95bc, 2'b01);
    tick(3);
    chk("acq_3rd_edge", rx_synced_o, 0);
    tick();
    chk("acq_4th_edge", rx_synced_o, 1);
    chk("acq_errcnt", err_cnt_o, 0);

    word(16'ha5a5, 2'b00);
    tick();
    chk("fwd_valid", rx_valid_o, 1);
    chk("fwd_data", rx_data_o, 32'ha5a5);
    chk("fwd_k", rx_k_o, 0);
    word(16'h95bc, 2'b01);
    tick();
    chk("idle_valid", rx_valid_o, 0);
    chk("idle_data", rx_data_o, 32'h95bc);

    // three errors without an IDLE between drop sync
    word(16'h1234, 2'b00);
    rx_enc_err_i = 1'b1;
    tick(2);
    chk("err2_synced", rx_synced_o, 1);
    chk("err_valid", rx_valid_o, 0);
    tick();
    rx_enc_err_i = 1'b0;
    chk("err3_synced", rx_synced_o, 0);
    chk("err3_losscnt", sync_loss_cnt_o, 1);
    chk("err3_errcnt", err_cnt_o, 3);

    acquire("reacq1");
    word(16'h1234, 2'b00);
    rx_enc_err_i = 1'b1;
    tick(2);
    rx_enc_err_i = 1'b0;
    word(16'h95bc, 2'b01);
    tick();
    word(16'h1234, 2'b01);
    tick();
    chk("errwin_keep", rx_synced_o, 1);
    chk("errwin_errcnt", err_cnt_o, 6);
    chk("kerr_valid", rx_valid_o, 0);

    word(16'h95bc, 2'b01);
    rx_resync_i = 1'b1;
    tick();
    chk("resync_drop", rx_synced_o, 0);
    cnt = 1;
    while (!rx_synced_o && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("resync_edges", cnt, 15);
    seen = 0;
    for (int i = cnt; i < 100; i++) begin
      tick();
      if (!rx_synced_o) seen = 1;
    end
    chk("resync_held_once", 32'(seen), 0);
    rx_resync_i = 1'b0;
    tick();

    // missing IDLE for the full gap
    word(16'h1234, 2'b00);
    tick(63);
    chk("gap63_synced", rx_synced_o, 1);
    chk("gap63_valid", rx_valid_o, 1);
    tick();
    chk("gap64_synced", rx_synced_o, 0);
    chk("gap64_valid", rx_valid_o, 0);
    chk("gap64_losscnt", sync_loss_cnt_o, 2);

    acquire("reacq2");
    rx_buf_err_i = 1'b1;
    tick();
    rx_buf_err_i = 1'b0;
    chk("buferr_synced", rx_synced_o, 0);
    chk("buferr_losscnt", sync_loss_cnt_o, 3);
    chk("buferr_errcnt", err_cnt_o, 7);

    // loss and resync together: counted, and goes through BLIND
    acquire("reacq3");
    rx_buf_err_i = 1'b1;
    rx_resync_i  = 1'b1;
    tick();
    rx_buf_err_i = 1'b0;
    chk("lossresync_synced", rx_synced_o, 0);
    chk("lossresync_losscnt", sync_loss_cnt_o, 4);
    chk("lossresync_errcnt", err_cnt_o, 8);
    tick(13);
    chk("lossresync_blind", rx_synced_o, 0);
    tick();
    chk("lossresync_resynced", rx_synced_o, 1);
    rx_resync_i = 1'b0;

    word(16'ha5a5, 2'b00);
    tick();
    chk("pre_rst_valid", rx_valid_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_synced", rx_synced_o, 0);
    chk("midrst_valid", rx_valid_o, 0);
    chk("midrst_data", rx_data_o, 0);
    chk("midrst_errcnt", err_cnt_o, 0);
    chk("midrst_losscnt", sync_loss_cnt_o, 0);
    #3;
    rst_n_i = 1'b1;

    // rx_rdy_i drop mid-ACQUIRE clears the acq count
    word(16'h95bc, 2'b01);
    tick(3);
    rx_rdy_i = 1'b0;
    tick();
    rx_rdy_i = 1'b1;
    tick();
    tick(3);
    chk("rdydrop_3idle", rx_synced_o, 0);
    tick();
    chk("rdydrop_4idle", rx_synced_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
